iob_uart16550_stream_bridge: RTL and testbench
==============================================

// Module: iob_uart16550_stream_bridge
// PURPOSE
//  Upstream master for the iob_uart16550 native-interface wrapper. After reset it programs the 16550:
//  baud divisor, 8N1 framing, FIFOs enabled. It then converts a byte TX stream into THR writes and
//  LSR-polled RBR reads into a byte RX stream. Its m_* port connects directly to the UART's
//  valid/address/wdata/wstrb/rdata/ready port.
// PARAMETERS
//  DATA_W       32     native bus data width (byte lanes = DATA_W/8)
//  UART_ADDR_W  3      UART register address width (byte address, regs 0..7)
//  BAUD_DIV     16'd27 16550 divisor latch value {DLM,DLL}
// PORTS
//  clk        in   1            system clock
//  rst        in   1            reset: asynchronous, active-high
//  tx_data    in   8            byte to transmit
//  tx_valid   in   1            tx_data valid
//  tx_ready   out  1            bridge accepts tx_data this cycle
//  rx_data    out  8            received byte
//  rx_valid   out  1            rx_data valid
//  rx_ready   in   1            consumer takes rx_data
//  init_done  out  1            UART configured
//  lsr_err    out  1            sticky: an LSR poll saw OE/PE/FE/BI (LSR[4:1]) set
//  m_valid    out  1            native request valid
//  m_address  out  UART_ADDR_W  register byte address
//  m_wdata    out  DATA_W       write data, byte placed in lane address[1:0]
//  m_wstrb    out  DATA_W/8     write strobe; all-zero means read
//  m_rdata    in   DATA_W       read data; byte taken from lane address[1:0]
//  m_ready    in   1            transaction complete
// BEHAVIOUR
//  Reset: m_valid=0, m_address=0, m_wdata=0, m_wstrb=0, rx_valid=0, init_done=0, lsr_err=0.
//   tx_ready=1 (holding register empty). Reset mid-transaction aborts it: m_valid drops and init restarts.
//  Bus rule: m_valid/m_address/m_wdata/m_wstrb are registered and held stable until m_ready=1 is sampled.
//   m_valid goes 0 in the next cycle and stays 0 for at least 1 cycle between transactions.
//   m_rdata is captured in the m_ready cycle. Lane: wdata=byte<<(8*addr[1:0]); wstrb=1<<addr[1:0].
//  FSM: INIT_LCR1(wr 3,0x83) -> INIT_DLL(wr 0,BAUD_DIV[7:0]) -> INIT_DLM(wr 1,BAUD_DIV[15:8])
//   -> INIT_LCR2(wr 3,0x03) -> INIT_FCR(wr 2,0x07) -> IDLE. init_done=1 from IDLE entry onward.
//   Each INIT state advances on m_ready.
//  IDLE: if tx_full or (RX path and !rx_full) -> POLL (rd 5). Otherwise stay.
//  POLL done: capture LSR. lsr_err |= |LSR[4:1].
//   can_tx = LSR[5] & tx_full; can_rx = LSR[0] & !rx_full.
//   If only one is true, go to TX_WR (wr 0,tx byte) or RX_RD (rd 0). If neither is true, go to IDLE.
//   If both are true: round-robin. A last_tx flag picks RX if the last serviced op was TX, else TX.
//  TX_WR done: tx_full<=0, last_tx<=1. RX_RD done: rx byte<=m_rdata lane 0, rx_full<=1, last_tx<=0. Both -> IDLE.
//  TX holding reg: tx_ready=!tx_full. A byte is accepted on tx_valid&tx_ready, also during init.
//   The accept and TX_WR-done events cannot coincide (tx_ready=0 while full).
//  RX holding reg: rx_valid=rx_full. Pop on rx_valid&rx_ready. RBR is read only when rx_full=0.
//   Backpressure therefore leaves bytes in the UART FIFO.
//  Latency: with the wrapper's 1-cycle registered ack, one poll+write is <=6 cycles from IDLE.
// CONFIGURATION
//  UART_BRIDGE_RX_EN defined: RX path as above.
//  Undefined: rx_valid=0 and rx_data=0 constant, can_rx=0, no RBR reads.
//   POLL only occurs when tx_full. lsr_err still functions.
// STRUCTURE
//  Shared package iob_uart16550_bridge_pkg holds:
//   register addresses (RBR/THR=0, DLL=0, DLM=1, FCR=2, LCR=3, LSR=5);
//   LSR bit indices (DR=0, THRE=5, err=4:1); init values 0x83/0x03/0x07; FSM state encoding.
//  One sub-module: iob_uart16550_bridge_hreg. It is a 1-byte valid/ready holding register,
//   instantiated twice (TX and RX).
// TESTING
//  Reset release -> exactly 5 writes: (3,wdata 0x83000000,wstrb 1000), (0,BAUD_DIV[7:0],0001),
//   (1,BAUD_DIV[15:8]<<8,0010), (3,0x03000000,1000), (2,0x00070000,0100). Then init_done=1.
//  tx_data=0x55 pulse, LSR reads 0x60 -> read addr 5 wstrb 0000.
//   Then write addr 0 wdata 0x00000055 wstrb 0001. tx_ready returns to 1.
//  LSR returns 0x00 three times then 0x20 -> 4 polls, one THR write.
//   m_valid is low >=1 cycle between every transaction.
//  [RX_EN] LSR 0x01 with RBR 0xA5, rx_ready=0 -> rx_data=0xA5, rx_valid=1, no further RBR reads.
//   After rx_ready=1 for one cycle, the next RBR read is allowed.
//  LSR 0x21 with tx byte pending and rx empty, twice -> TX then RX serviced (round-robin).
//   LSR 0x03 sets lsr_err=1 and it stays set.
//  Assert rst while m_valid=1 in TX_WR -> m_valid=0 immediately.
//   tx byte discarded, init sequence restarts from LCR 0x83. Macro undefined -> rx_valid never 1.

Source files
------------

// File: rtl/iob_uart16550_bridge_pkg.sv
// Shared definitions for the iob_uart16550 stream bridge: 16550 register map,
// LSR bit positions, init register values and the bridge FSM encoding.
package iob_uart16550_bridge_pkg;

  // 16550 register byte addresses (DLL/DLM overlay RBR/THR/IER while LCR.DLAB=1)
  localparam int unsigned ADDR_RBR = 0;
  localparam int unsigned ADDR_THR = 0;
  localparam int unsigned ADDR_DLL = 0;
  localparam int unsigned ADDR_DLM = 1;
  localparam int unsigned ADDR_FCR = 2;
  localparam int unsigned ADDR_LCR = 3;
  localparam int unsigned ADDR_LSR = 5;

  // LSR bits: data ready, THR empty, error field OE/PE/FE/BI
  localparam int unsigned LSR_DR     = 0;
  localparam int unsigned LSR_THRE   = 5;
  localparam int unsigned LSR_ERR_LO = 1;
  localparam int unsigned LSR_ERR_HI = 4;

  // LCR with DLAB set and 8N1, LCR 8N1 with DLAB clear, FCR enable + clear both FIFOs
  localparam logic [7:0] LCR_DLAB_8N1 = 8'h83;
  localparam logic [7:0] LCR_8N1      = 8'h03;
  localparam logic [7:0] FCR_INIT     = 8'h07;

  typedef enum logic [3:0] {
    ST_INIT_LCR1,
    ST_INIT_DLL,
    ST_INIT_DLM,
    ST_INIT_LCR2,
    ST_INIT_FCR,
    ST_IDLE,
    ST_POLL,
    ST_TX_WR,
    ST_RX_RD
  } bridge_state_t;

  function automatic logic lsr_has_err(input logic [7:0] lsr);
    return |lsr[LSR_ERR_HI:LSR_ERR_LO];
  endfunction

endpackage

// File: rtl/iob_uart16550_bridge_hreg.sv
// One-byte valid/ready holding register. Write side loads when empty, read side
// drains when full; the two can never fire in the same cycle.
module iob_uart16550_bridge_hreg
  import iob_uart16550_bridge_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] wr_data,
  input  logic       wr_valid,
  output logic       wr_ready,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  input  logic       rd_ready
);

  logic       full;
  logic [7:0] data;

  // Fill on an accepted write, empty on an accepted read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full <= 1'b0;
      data <= 8'h00;
    end else if (wr_valid && !full) begin
      full <= 1'b1;
      data <= wr_data;
    end else if (full && rd_ready) begin
      full <= 1'b0;
    end
  end

  assign wr_ready = !full;
  assign rd_valid = full;
  assign rd_data  = data;

endmodule

// File: rtl/iob_uart16550_stream_bridge.sv
// Upstream master for the iob_uart16550 native interface. Programs divisor,
// 8N1 framing and FIFOs after reset, then moves a TX byte stream into THR writes
// and LSR-polled RBR reads into an RX byte stream.
// Build option: define UART_BRIDGE_RX_EN to include the RX path; without it the
// bridge is TX-only (rx_valid/rx_data tied low, no RBR reads).
//
// state     | meaning
// INIT_LCR1 | write LCR=0x83 (DLAB on, 8N1)
// INIT_DLL  | write divisor low byte
// INIT_DLM  | write divisor high byte
// INIT_LCR2 | write LCR=0x03 (DLAB off, 8N1)
// INIT_FCR  | write FCR=0x07 (FIFOs on and cleared)
// IDLE      | configured, wait for work
// POLL      | read LSR, choose TX/RX/none
// TX_WR     | write held TX byte to THR
// RX_RD     | read RBR into RX holding register
module iob_uart16550_stream_bridge
  import iob_uart16550_bridge_pkg::*;
#(
  parameter int          DATA_W      = 32,
  parameter int          UART_ADDR_W = 3,
  parameter logic [15:0] BAUD_DIV    = 16'd27
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             tx_data,
  input  logic                   tx_valid,
  output logic                   tx_ready,
  output logic [7:0]             rx_data,
  output logic                   rx_valid,
  input  logic                   rx_ready,
  output logic                   init_done,
  output logic                   lsr_err,
  output logic                   m_valid,
  output logic [UART_ADDR_W-1:0] m_address,
  output logic [DATA_W-1:0]      m_wdata,
  output logic [DATA_W/8-1:0]    m_wstrb,
  input  logic [DATA_W-1:0]      m_rdata,
  input  logic                   m_ready
);

  localparam int STRB_W = DATA_W / 8;

  bridge_state_t          state;
  logic                   last_tx;
  logic [UART_ADDR_W-1:0] req_addr;
  logic [7:0]             req_byte;
  logic                   req_wr;
  logic [1:0]             rd_lane;
  logic [7:0]             rd_byte;
  logic [7:0]             tx_byte;
  logic                   tx_full;
  logic                   tx_pop;
  logic                   rx_push;
  logic                   rx_full;
  logic                   bus_done;
  logic                   can_tx;
  logic                   can_rx;

  assign bus_done = m_valid && m_ready;
  assign rd_lane  = m_address[1:0];
  assign rd_byte  = m_rdata[{rd_lane, 3'b000} +: 8];
  assign tx_pop   = (state == ST_TX_WR) && bus_done;
  assign rx_push  = (state == ST_RX_RD) && bus_done;

  iob_uart16550_bridge_hreg u_tx_hreg (
    .clk      (clk),
    .rst      (rst),
    .wr_data  (tx_data),
    .wr_valid (tx_valid),
    .wr_ready (tx_ready),
    .rd_data  (tx_byte),
    .rd_valid (tx_full),
    .rd_ready (tx_pop)
  );

`ifdef UART_BRIDGE_RX_EN
  localparam bit RX_EN = 1'b1;
  logic rx_wr_ready;

  iob_uart16550_bridge_hreg u_rx_hreg (
    .clk      (clk),
    .rst      (rst),
    .wr_data  (rd_byte),
    .wr_valid (rx_push),
    .wr_ready (rx_wr_ready),
    .rd_data  (rx_data),
    .rd_valid (rx_valid),
    .rd_ready (rx_ready)
  );

  assign rx_full = !rx_wr_ready;
`else
  localparam bit RX_EN = 1'b0;
  logic unused_rx;

  assign rx_data   = 8'h00;
  assign rx_valid  = 1'b0;
  assign rx_full   = 1'b0;
  assign unused_rx = ^{rx_ready, rx_push, rd_byte[7:6]};
`endif

  assign can_tx = rd_byte[LSR_THRE] && tx_full;
  assign can_rx = RX_EN && rd_byte[LSR_DR] && !rx_full;

  // Register access implied by the current state
  always_comb begin
    req_addr = '0;
    req_byte = 8'h00;
    req_wr   = 1'b1;
    case (state)
      ST_INIT_LCR1: begin req_addr = UART_ADDR_W'(ADDR_LCR); req_byte = LCR_DLAB_8N1;   end
      ST_INIT_DLL:  begin req_addr = UART_ADDR_W'(ADDR_DLL); req_byte = BAUD_DIV[7:0];  end
      ST_INIT_DLM:  begin req_addr = UART_ADDR_W'(ADDR_DLM); req_byte = BAUD_DIV[15:8]; end
      ST_INIT_LCR2: begin req_addr = UART_ADDR_W'(ADDR_LCR); req_byte = LCR_8N1;        end
      ST_INIT_FCR:  begin req_addr = UART_ADDR_W'(ADDR_FCR); req_byte = FCR_INIT;       end
      ST_POLL:      begin req_addr = UART_ADDR_W'(ADDR_LSR); req_wr   = 1'b0;           end
      ST_TX_WR:     begin req_addr = UART_ADDR_W'(ADDR_THR); req_byte = tx_byte;        end
      ST_RX_RD:     begin req_addr = UART_ADDR_W'(ADDR_RBR); req_wr   = 1'b0;           end
      default:      begin req_wr   = 1'b0;                                              end
    endcase
  end

  // Sequencer: every bus state raises a request from idle bus, then advances on
  // m_ready; the drop of m_valid on completion guarantees a one-cycle gap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_INIT_LCR1;
      m_valid   <= 1'b0;
      m_address <= '0;
      m_wdata   <= '0;
      m_wstrb   <= '0;
      init_done <= 1'b0;
      lsr_err   <= 1'b0;
      last_tx   <= 1'b0;
    end else if (state == ST_IDLE) begin
      if (tx_full || (RX_EN && !rx_full)) begin
        state <= ST_POLL;
      end
    end else if (!m_valid) begin
      m_valid   <= 1'b1;
      m_address <= req_addr;
      m_wdata   <= DATA_W'(req_byte) << {req_addr[1:0], 3'b000};
      m_wstrb   <= req_wr ? (STRB_W'(1) << req_addr[1:0]) : '0;
    end else if (m_ready) begin
      m_valid <= 1'b0;
      case (state)
        ST_INIT_LCR1: state <= ST_INIT_DLL;
        ST_INIT_DLL:  state <= ST_INIT_DLM;
        ST_INIT_DLM:  state <= ST_INIT_LCR2;
        ST_INIT_LCR2: state <= ST_INIT_FCR;
        ST_INIT_FCR: begin
          state     <= ST_IDLE;
          init_done <= 1'b1;
        end
        ST_POLL: begin
          lsr_err <= lsr_err | lsr_has_err(rd_byte);
          if (can_tx && can_rx) begin
            state <= last_tx ? ST_RX_RD : ST_TX_WR;
          end else if (can_tx) begin
            state <= ST_TX_WR;
          end else if (can_rx) begin
            state <= ST_RX_RD;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_TX_WR: begin
          last_tx <= 1'b1;
          state   <= ST_IDLE;
        end
        ST_RX_RD: begin
          last_tx <= 1'b0;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iob_uart16550_stream_bridge.sv
// Self-checking bench for iob_uart16550_stream_bridge. A behavioural UART slave
// acks each request one half-cycle later, returns scripted LSR/RBR bytes and
// logs every transaction; expectations come from the register-level rules.
module tb_iob_uart16550_stream_bridge;

  localparam logic [15:0] BAUD = 16'd27;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        init_done;
  logic        lsr_err;
  logic        m_valid;
  logic [2:0]  m_address;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic [31:0] m_rdata = 32'h0;
  logic        m_ready = 1'b0;

  typedef struct {
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } txn_t;

  txn_t       log_q[$];
  logic [7:0] lsr_q[$];
  logic [7:0] rbr_q[$];
  int         checks = 0;
  int         errors = 0;
  bit         stall_thr = 1'b0;
  bit         rx_seen = 1'b0;

  iob_uart16550_stream_bridge dut (
    .clk       (clk),
    .rst       (rst),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .init_done (init_done),
    .lsr_err   (lsr_err),
    .m_valid   (m_valid),
    .m_address (m_address),
    .m_wdata   (m_wdata),
    .m_wstrb   (m_wstrb),
    .m_rdata   (m_rdata),
    .m_ready   (m_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lane_w(input int addr, input logic [7:0] b);
    logic [31:0] w;
    w = {24'h0, b};
    return w << (8 * (addr % 4));
  endfunction

  function automatic logic [3:0] strb_of(input int addr, input bit wr);
    logic [3:0] s;
    s = 4'b0001;
    return wr ? (s << (addr % 4)) : 4'b0000;
  endfunction

  function automatic int find_thr_write();
    for (int i = 0; i < log_q.size(); i++)
      if (log_q[i].addr == 3'd0 && log_q[i].wstrb != 4'd0) return i;
    return -1;
  endfunction

  function automatic int count_txn(input int addr, input bit wr, input int from);
    int n;
    n = 0;
    for (int i = from; i < log_q.size(); i++)
      if (log_q[i].addr == 3'(addr) && ((log_q[i].wstrb != 4'd0) == wr)) n++;
    return n;
  endfunction

  task automatic chk_txn(input string tag, input int idx, input int addr,
                         input logic [7:0] b, input bit wr);
    if (idx >= log_q.size()) begin
      chk({tag, "_missing"}, log_q.size(), idx + 1);
    end else begin
      chk({tag, "_addr"}, {29'h0, log_q[idx].addr}, addr);
      chk({tag, "_wstrb"}, {28'h0, log_q[idx].wstrb}, {28'h0, strb_of(addr, wr)});
      if (wr) chk({tag, "_wdata"}, log_q[idx].wdata, lane_w(addr, b));
    end
  endtask

  task automatic wait_log(input string tag, input int n);
    for (int c = 0; c < 200 && log_q.size() < n; c++) begin
      @(posedge clk); #1;
    end
    chk(tag, (log_q.size() >= n), 1);
  endtask

  task automatic wait_thr(input string tag, output int pos);
    pos = find_thr_write();
    for (int c = 0; c < 300 && pos < 0; c++) begin
      @(posedge clk); #1;
      pos = find_thr_write();
    end
    chk(tag, (pos >= 0), 1);
  endtask

  task automatic check_init(input string tag);
    int          a[5];
    logic [7:0]  b[5];
    a = '{3, 0, 1, 3, 2};
    b = '{8'h83, BAUD[7:0], BAUD[15:8], 8'h03, 8'h07};
    wait_log({tag, "_count"}, 5);
    for (int i = 0; i < 5; i++) chk_txn($sformatf("%s_w%0d", tag, i), i, a[i], b[i], 1'b1);
    @(posedge clk); #1;
    chk({tag, "_done"}, init_done, 1);
  endtask

  // Push one byte into the TX holding register and let the bridge see it
  task automatic push_tx(input logic [7:0] b);
    @(posedge clk); #1;
    chk("tx_ready_before", tx_ready, 1);
    tx_data  = b;
    tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    chk("tx_ready_full", tx_ready, 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // UART slave model: ack each request half a cycle after it appears
  always @(negedge clk) begin : slave
    txn_t        t;
    logic [31:0] rd;
    logic [7:0]  val;
    if (rst) begin
      m_ready = 1'b0;
    end else if (m_ready) begin
      m_ready = 1'b0;
      chk("bus_gap", m_valid, 0);
    end else if (m_valid && !(stall_thr && m_address == 3'd0 && m_wstrb != 4'd0)) begin
      t.addr  = m_address;
      t.wdata = m_wdata;
      t.wstrb = m_wstrb;
      log_q.push_back(t);
      val = 8'h00;
      if (m_wstrb == 4'd0 && m_address == 3'd5 && lsr_q.size() > 0) val = lsr_q.pop_front();
      if (m_wstrb == 4'd0 && m_address == 3'd0 && rbr_q.size() > 0) val = rbr_q.pop_front();
      rd = $urandom;
      rd[{m_address[1:0], 3'b000} +: 8] = val;
      m_rdata = rd;
      m_ready = 1'b1;
    end
  end

  always @(negedge clk) if (rx_valid === 1'b1) rx_seen = 1'b1;

  initial begin
    logic [7:0] b;
    logic [7:0] last_lsr;
    int         k;
    int         pos;
    int         nread;
    rst      = 1'b1;
    tx_data  = 8'h00;
    tx_valid = 1'b0;
    rx_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_address", {29'h0, m_address}, 0);
    chk("rst_m_wdata", m_wdata, 0);
    chk("rst_m_wstrb", {28'h0, m_wstrb}, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_lsr_err", lsr_err, 0);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_rx_valid", rx_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    check_init("init");

    // TX: random byte, k polls with THRE clear, then THRE set
    for (int it = 0; it < 6; it++) begin
      b = 8'($urandom);
      k = $urandom_range(0, 3);
      last_lsr = ($urandom_range(0, 1) == 1) ? 8'h60 : 8'h20;
      push_tx(b);
      log_q.delete();
      for (int j = 0; j < k; j++) lsr_q.push_back(8'h00);
      lsr_q.push_back(last_lsr);
      wait_thr("tx_thr_seen", pos);
      chk("tx_poll_count", pos, k + 1);
      for (int j = 0; j <= k; j++) chk_txn("tx_poll", j, 5, 8'h00, 1'b0);
      chk_txn("tx_thr", k + 1, 0, b, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      chk("tx_ready_back", tx_ready, 1);
    end
    chk("lsr_err_clean", lsr_err, 0);

    // LSR error bits become sticky
    b = 8'($urandom);
    push_tx(b);
    log_q.delete();
    lsr_q.push_back(8'($urandom_range(1, 15)) << 1);
    lsr_q.push_back(8'h20);
    wait_thr("err_thr_seen", pos);
    chk_txn("err_thr", pos, 0, b, 1'b1);
    chk("lsr_err_set", lsr_err, 1);
    repeat (20) @(posedge clk);
    #1;
    chk("lsr_err_sticky", lsr_err, 1);

`ifdef UART_BRIDGE_RX_EN
    // RX with backpressure: one RBR read, then no further reads until popped
    rx_ready = 1'b0;
    b = 8'($urandom);
    log_q.delete();
    rbr_q.push_back(b);
    lsr_q.push_back(8'h01);
    for (int c = 0; c < 200 && !rx_valid; c++) begin @(posedge clk); #1; end
    chk("rx_valid_set", rx_valid, 1);
    chk("rx_data", {24'h0, rx_data}, {24'h0, b});
    repeat (30) @(posedge clk);
    #1;
    nread = count_txn(0, 1'b0, 0);
    chk("rx_single_read", nread, 1);
    chk("rx_no_polls_full", log_q[log_q.size()-1].addr == 3'd0, 1);
    rx_ready = 1'b1;
    @(posedge clk); #1;
    rx_ready = 1'b0;
    chk("rx_popped", rx_valid, 0);
    b = 8'($urandom);
    rbr_q.push_back(b);
    lsr_q.push_back(8'h01);
    for (int c = 0; c < 200 && !rx_valid; c++) begin @(posedge clk); #1; end
    chk("rx2_data", {24'h0, rx_data}, {24'h0, b});
    rx_ready = 1'b1;
    @(posedge clk); #1;
    rx_ready = 1'b0;

    // Round-robin: last op RX -> TX wins; then last op TX -> RX wins
    b = 8'($urandom);
    push_tx(b);
    log_q.delete();
    lsr_q.push_back(8'h21);
    wait_thr("rr1_thr_seen", pos);
    chk_txn("rr1_thr", pos, 0, b, 1'b1);
    chk("rr1_no_rbr", count_txn(0, 1'b0, 0), 0);
    b = 8'($urandom);
    push_tx(b);
    log_q.delete();
    rbr_q.push_back(8'h3C);
    lsr_q.push_back(8'h21);
    lsr_q.push_back(8'h21);
    wait_thr("rr2_thr_seen", pos);
    chk("rr2_rbr_before_thr", count_txn(0, 1'b0, 0) == 1 && count_txn(0, 1'b0, pos) == 0, 1);
    chk_txn("rr2_thr", pos, 0, b, 1'b1);
    chk("rr2_rx_data", {24'h0, rx_data}, 32'h3C);
    rx_ready = 1'b1;
    @(posedge clk); #1;
    rx_ready = 1'b0;
`endif

    // Reset while THR write is outstanding
    stall_thr = 1'b1;
    b = 8'($urandom);
    push_tx(b);
    lsr_q.push_back(8'h20);
    pos = -1;
    for (int c = 0; c < 200 && pos < 0; c++) begin
      @(posedge clk); #1;
      if (m_valid && m_address == 3'd0 && m_wstrb != 4'd0) pos = c;
    end
    chk("rst_mid_found", (pos >= 0), 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_m_valid", m_valid, 0);
    chk("rst_mid_tx_ready", tx_ready, 1);
    chk("rst_mid_init_done", init_done, 0);
    chk("rst_mid_lsr_err", lsr_err, 0);
    stall_thr = 1'b0;
    lsr_q.delete();
    rbr_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    log_q.delete();
    rst = 1'b0;
    check_init("reinit");
    repeat (30) @(posedge clk);
    #1;
    chk("rst_tx_discarded", count_txn(0, 1'b1, 5), 0);

`ifndef UART_BRIDGE_RX_EN
    chk("rx_never_valid", rx_seen, 0);
    chk("no_rbr_reads", count_txn(0, 1'b0, 0), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
